// File: rtl/muldiv_seq_ctrl.sv
// Iterative RV32M sequencer: shift-add multiply / restoring divide on operand magnitudes, sign fixed at the end.
// Latency: done_o 32 cycles after the start cycle (1 cycle for divide-by-zero / signed overflow).
// Backpressure: stall_o holds IF/ID/EX from the start cycle through the last RUN cycle; starts during RUN are ignored.
module muldiv_seq_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] acc;
        logic [XLEN-1:0] sh;
    } step_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] shreg;
    logic [XLEN-1:0] opnd;
    logic [2:0]      op;
    logic            sa;
    logic            sb;

    // acc is the product high half / partial remainder; sh is multiplier+product low half / dividend+quotient.
    function automatic step_t iterate(input logic            div,
                                      input logic [XLEN-1:0] acc_q,
                                      input logic [XLEN-1:0] sh_q,
                                      input logic [XLEN-1:0] d);
        step_t           r;
        logic [XLEN-1:0] addend;
        logic [XLEN:0]   sum;
        logic [XLEN:0]   diff;
        addend = sh_q[0] ? d : {XLEN{1'b0}};
        sum    = {1'b0, acc_q} + {1'b0, addend};
        diff   = {acc_q, sh_q[XLEN-1]} - {1'b0, d};
        if (div) begin
            if (!diff[XLEN]) begin
                r.acc = diff[XLEN-1:0];
                r.sh  = {sh_q[XLEN-2:0], 1'b1};
            end else begin
                r.acc = {acc_q[XLEN-2:0], sh_q[XLEN-1]};
                r.sh  = {sh_q[XLEN-2:0], 1'b0};
            end
        end else begin
            r.acc = sum[XLEN:1];
            r.sh  = {sum[0], sh_q[XLEN-1:1]};
        end
        return r;
    endfunction

    logic            in_div;
    logic            in_sa;
    logic            in_sb;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            b_zero;
    logic            ovf;
    logic            in_special;
    logic [XLEN-1:0] special_res;
    step_t           first;
    step_t           nxt;

    always_comb begin
        in_div = funct3_i[2];
        in_sa  = a_i[XLEN-1] & (in_div ? ~funct3_i[0]
                                       : (funct3_i[1:0] == 2'b01 || funct3_i[1:0] == 2'b10));
        in_sb  = b_i[XLEN-1] & (in_div ? ~funct3_i[0] : (funct3_i[1:0] == 2'b01));
        a_mag  = in_sa ? -a_i : a_i;
        b_mag  = in_sb ? -b_i : b_i;
        b_zero = (b_i == {XLEN{1'b0}});
        ovf    = ~funct3_i[0] && (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (&b_i);
        in_special = in_div && (b_zero || ovf);
        if (b_zero)
            special_res = funct3_i[1] ? a_i : {XLEN{1'b1}};
        else
            special_res = funct3_i[1] ? {XLEN{1'b0}} : a_i;
        // The first iteration runs on the accept edge, so RUN needs only XLEN-1 more.
        first = iterate(in_div, {XLEN{1'b0}}, in_div ? a_mag : b_mag, in_div ? b_mag : a_mag);
        nxt   = iterate(op[2], acc, shreg, opnd);
    end

    logic [2*XLEN-1:0] product;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s;
    logic [XLEN-1:0]   rem_s;
    logic [XLEN-1:0]   final_res;

    always_comb begin
        product = {nxt.acc, nxt.sh};
        prod_s  = (sa ^ sb) ? -product : product;
        quo_s   = (sa ^ sb) ? -nxt.sh : nxt.sh;
        rem_s   = sa ? -nxt.acc : nxt.acc;
        if (op[2])
            final_res = op[1] ? rem_s : quo_s;
        else if (op[1:0] == 2'b00)
            final_res = prod_s[XLEN-1:0];
        else
            final_res = prod_s[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            shreg    <= '0;
            opnd     <= '0;
            op       <= '0;
            sa       <= 1'b0;
            sb       <= 1'b0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            result_o <= '0;
        end else if (flush_i) begin
            state  <= IDLE;
            cnt    <= '0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_i) begin
                        op <= funct3_i;
                        sa <= in_sa;
                        sb <= in_sb;
                        if (in_special) begin
                            state    <= DONE;
                            result_o <= special_res;
                            busy_o   <= 1'b0;
                            done_o   <= 1'b1;
                        end else begin
                            state  <= RUN;
                            cnt    <= CW'(XLEN);
                            acc    <= first.acc;
                            shreg  <= first.sh;
                            opnd   <= in_div ? b_mag : a_mag;
                            busy_o <= 1'b1;
                            done_o <= 1'b0;
                        end
                    end else begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                        done_o <= 1'b0;
                    end
                end
                RUN: begin
                    acc   <= nxt.acc;
                    shreg <= nxt.sh;
                    cnt   <= cnt - 1'b1;
                    if (cnt == CW'(2)) begin
                        state    <= DONE;
                        result_o <= final_res;
                        busy_o   <= 1'b0;
                        done_o   <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                    done_o <= 1'b0;
                end
            endcase
        end
    end

    assign stall_o = start_i | busy_o;

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Bench for muldiv_seq_ctrl: latency/result reference model checked every cycle, plus directed literal cases.
module tb_muldiv_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i;
    logic [2:0]  funct3_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        flush_i;
    logic        busy_o;
    logic        stall_o;
    logic        done_o;
    logic [31:0] result_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    muldiv_seq_ctrl #(.XLEN(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start_i  (start_i),
        .funct3_i (funct3_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .flush_i  (flush_i),
        .busy_o   (busy_o),
        .stall_o  (stall_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        return f3[2] && (b == 32'd0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] w;
        case (f3)
            3'd0: w = {32'd0, a} * {32'd0, b};
            3'd1: w = longint'($signed(a)) * longint'($signed(b));
            3'd2: w = longint'($signed(a)) * longint'({32'd0, b});
            3'd3: w = {32'd0, a} * {32'd0, b};
            3'd4: begin
                if (b == 0) w = 64'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) w = 64'h8000_0000;
                else w = longint'($signed(a)) / longint'($signed(b));
            end
            3'd5: w = (b == 0) ? 64'hFFFF_FFFF : {32'd0, a / b};
            3'd6: begin
                if (b == 0) w = {32'd0, a};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) w = 64'd0;
                else w = longint'($signed(a)) % longint'($signed(b));
            end
            default: w = (b == 0) ? {32'd0, a} : {32'd0, a % b};
        endcase
        if (f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd3) return w[63:32];
        return w[31:0];
    endfunction

    // Model: cycles left until the result appears, and the results in flight / on display.
    int          m_cnt = 0;
    logic        m_done = 1'b0;
    logic        m_valid = 1'b0;
    logic [31:0] m_pending = 32'd0;
    logic [31:0] m_result = 32'd0;

    always @(posedge clk) begin
        if (reset) begin
            m_cnt = 0; m_done = 1'b0; m_result = 32'd0; m_valid = 1'b1;
        end else if (flush_i) begin
            m_cnt = 0; m_done = 1'b0;
        end else if (start_i && m_cnt == 0) begin
            m_pending = ref_result(funct3_i, a_i, b_i);
            m_cnt = is_special(funct3_i, a_i, b_i) ? 0 : 31;
            m_done = (m_cnt == 0);
            if (m_done) m_result = m_pending;
        end else if (m_cnt > 0) begin
            m_cnt--;
            m_done = (m_cnt == 0);
            if (m_done) m_result = m_pending;
        end else begin
            m_done = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("cyc_busy",   {31'd0, busy_o},  {31'd0, m_cnt > 0});
            check("cyc_done",   {31'd0, done_o},  {31'd0, m_done});
            check("cyc_stall",  {31'd0, stall_o}, {31'd0, start_i || m_cnt > 0});
            check("cyc_result", result_o, m_result);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat, input int inject);
        int cyc;
        int stall_bad;
        start_i = 1'b1; funct3_i = f3; a_i = a; b_i = b;
        tick();
        start_i = 1'b0;
        cyc = 1;
        stall_bad = 0;
        while (!done_o && cyc < 100) begin
            if (!stall_o) stall_bad++;
            if (cyc == inject) begin
                start_i = 1'b1;
                funct3_i = 3'($urandom_range(7));
                a_i = $urandom;
                b_i = $urandom;
            end else begin
                start_i = 1'b0;
            end
            tick();
            cyc++;
        end
        start_i = 1'b0;
        check({name, "_done"}, {31'd0, done_o}, 32'd1);
        check({name, "_result"}, result_o, exp);
        check({name, "_latency"}, 32'(cyc), 32'(lat));
        check({name, "_stall_run"}, 32'(stall_bad), 32'd0);
        #1;
        check({name, "_stall_in_done"}, {31'd0, stall_o}, 32'd0);
        check({name, "_busy_in_done"}, {31'd0, busy_o}, 32'd0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int dones;
        reset = 1'b1; start_i = 1'b0; flush_i = 1'b0;
        funct3_i = 3'd0; a_i = 32'd0; b_i = 32'd0;
        tick();
        tick();
        check("reset_busy", {31'd0, busy_o}, 32'd0);
        check("reset_done", {31'd0, done_o}, 32'd0);
        check("reset_result", result_o, 32'd0);
        reset = 1'b0;
        tick();

        run_op("mul",    3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 32, 0);
        run_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32, 0);
        run_op("mulh",   3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32, 0);
        run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 32, 0);
        run_op("div",    3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32, 0);
        run_op("rem",    3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32, 0);
        run_op("divu",   3'd5, 32'd100,       32'd7,         32'd14,        32, 0);
        run_op("remu",   3'd7, 32'd100,       32'd7,         32'd2,         32, 0);
        run_op("divu_by0", 3'd5, 32'd5,       32'd0,         32'hFFFF_FFFF, 1, 0);
        run_op("rem_by0",  3'd6, 32'd5,       32'd0,         32'd5,         1, 0);
        run_op("div_ovf",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);

        // Flush in RUN cycle 10: no result, previous result retained.
        start_i = 1'b1; funct3_i = 3'd4; a_i = 32'd1000; b_i = 32'd3;
        tick();
        start_i = 1'b0;
        repeat (9) tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("flush_busy", {31'd0, busy_o}, 32'd0);
        check("flush_done", {31'd0, done_o}, 32'd0);
        check("flush_result_kept", result_o, 32'h8000_0000);
        dones = 0;
        repeat (40) begin
            tick();
            if (done_o) dones++;
        end
        check("flush_no_done", 32'(dones), 32'd0);
        run_op("div_after_flush", 3'd4, 32'd100, 32'd7, 32'd14, 32, 0);

        // Back-to-back starts issued in the DONE cycle, with a stray start mid-RUN.
        run_op("b2b_a", 3'd3, 32'd3, 32'd5, 32'd0, 32, 0);
        run_op("b2b_b", 3'd0, 32'd3, 32'd5, 32'd15, 32, 0);
        run_op("b2b_inject", 3'd7, 32'd1000, 32'd33, 32'd10, 32, 5);

        // Reset in RUN cycle 5.
        start_i = 1'b1; funct3_i = 3'd0; a_i = 32'd9; b_i = 32'd9;
        tick();
        start_i = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_run_busy", {31'd0, busy_o}, 32'd0);
        check("rst_run_done", {31'd0, done_o}, 32'd0);
        check("rst_run_stall", {31'd0, stall_o}, 32'd0);
        check("rst_run_result", result_o, 32'd0);
        tick();

        for (int i = 0; i < 3000; i++) begin
            start_i  = ($urandom_range(7) == 0);
            funct3_i = 3'($urandom_range(7));
            a_i      = pick_operand();
            b_i      = pick_operand();
            flush_i  = ($urandom_range(49) == 0);
            reset    = ($urandom_range(999) == 0);
            tick();
        end
        start_i = 1'b0; flush_i = 1'b0; reset = 1'b0;
        repeat (40) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
